// File: rtl/id_stage_if.sv
// IFID -> ID -> IDEX signal bundle for the decode stage, plus write-back and flush inputs.
// The slave modport is the decode stage; master is whoever drives IFID/WB and consumes IDEX.
interface id_stage_if #(parameter int DATA_W = 32);
  logic [DATA_W-1:0] IFID_pc_i;
  logic [31:0]       IFID_ir_i;
  logic              WB_reg_write_i;
  logic [4:0]        WB_write_reg_i;
  logic [DATA_W-1:0] WB_write_data_i;
  logic              MEM_ctrl_pc_src_i;
  logic              stall_o;
  logic [DATA_W-1:0] IDEX_pc_o;
  logic [DATA_W-1:0] IDEX_rs_data_o;
  logic [DATA_W-1:0] IDEX_rt_data_o;
  logic [DATA_W-1:0] IDEX_imm_o;
  logic [4:0]        IDEX_rt_o;
  logic [4:0]        IDEX_rd_o;
  logic              IDEX_ctrl_reg_dst_o;
  logic              IDEX_ctrl_alu_src_o;
  logic              IDEX_ctrl_branch_o;
  logic              IDEX_ctrl_mem_read_o;
  logic              IDEX_ctrl_mem_write_o;
  logic              IDEX_ctrl_reg_write_o;
  logic              IDEX_ctrl_mem_to_reg_o;
  logic [1:0]        IDEX_ctrl_alu_op_o;

  modport slave (
    input  IFID_pc_i, IFID_ir_i, WB_reg_write_i, WB_write_reg_i, WB_write_data_i,
           MEM_ctrl_pc_src_i,
    output stall_o, IDEX_pc_o, IDEX_rs_data_o, IDEX_rt_data_o, IDEX_imm_o, IDEX_rt_o,
           IDEX_rd_o, IDEX_ctrl_reg_dst_o, IDEX_ctrl_alu_src_o, IDEX_ctrl_branch_o,
           IDEX_ctrl_mem_read_o, IDEX_ctrl_mem_write_o, IDEX_ctrl_reg_write_o,
           IDEX_ctrl_mem_to_reg_o, IDEX_ctrl_alu_op_o
  );

  modport master (
    output IFID_pc_i, IFID_ir_i, WB_reg_write_i, WB_write_reg_i, WB_write_data_i,
           MEM_ctrl_pc_src_i,
    input  stall_o, IDEX_pc_o, IDEX_rs_data_o, IDEX_rt_data_o, IDEX_imm_o, IDEX_rt_o,
           IDEX_rd_o, IDEX_ctrl_reg_dst_o, IDEX_ctrl_alu_src_o, IDEX_ctrl_branch_o,
           IDEX_ctrl_mem_read_o, IDEX_ctrl_mem_write_o, IDEX_ctrl_reg_write_o,
           IDEX_ctrl_mem_to_reg_o, IDEX_ctrl_alu_op_o
  );
endinterface

// File: rtl/id_stage.sv
// MIPS decode stage: register file with WB bypass, control decode, sign-extend, IDEX registers.
// ID_HAZARD_DETECT_EN enables the load-use stall; without it stall_o is tied low.
module id_stage #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32
) (
  input  logic        clk_i,
  input  logic        n_rst_i,
  id_stage_if.slave   bus
);
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic        wb_en;
  logic        bubble;
  logic        stall;
  ctrl_t       dec_ctrl, ex_ctrl;

  logic [DATA_W-1:0] rf [NUM_REGS];
  logic [DATA_W-1:0] rs_data, rt_data, imm;
  logic [DATA_W-1:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]        ex_rt, ex_rd;

  assign opcode = bus.IFID_ir_i[31:26];
  assign rs     = bus.IFID_ir_i[25:21];
  assign rt     = bus.IFID_ir_i[20:16];
  assign rd     = bus.IFID_ir_i[15:11];
  assign imm    = {{(DATA_W-16){bus.IFID_ir_i[15]}}, bus.IFID_ir_i[15:0]};
  assign wb_en  = bus.WB_reg_write_i && (bus.WB_write_reg_i != 5'd0);

  always_comb begin
    dec_ctrl = '0;
    case (opcode)
      OP_RTYPE: dec_ctrl = '{reg_dst: 1'b1, reg_write: 1'b1, alu_op: 2'b10, default: '0};
      OP_LW:    dec_ctrl = '{alu_src: 1'b1, mem_to_reg: 1'b1, reg_write: 1'b1,
                             mem_read: 1'b1, default: '0};
      OP_SW:    dec_ctrl = '{alu_src: 1'b1, mem_write: 1'b1, default: '0};
      OP_BEQ:   dec_ctrl = '{branch: 1'b1, alu_op: 2'b01, default: '0};
      OP_ADDI:  dec_ctrl = '{alu_src: 1'b1, reg_write: 1'b1, default: '0};
      default:  dec_ctrl = '0;
    endcase
  end

  // Same-cycle WB forwarding so the operand is never the stale array value.
  always_comb begin
    rs_data = rf[rs];
    rt_data = rf[rt];
    if (wb_en && bus.WB_write_reg_i == rs) rs_data = bus.WB_write_data_i;
    if (wb_en && bus.WB_write_reg_i == rt) rt_data = bus.WB_write_data_i;
    if (rs == 5'd0) rs_data = '0;
    if (rt == 5'd0) rt_data = '0;
  end

`ifdef ID_HAZARD_DETECT_EN
  assign stall = ex_ctrl.mem_read && (ex_rt != 5'd0) && ((ex_rt == rs) || (ex_rt == rt));
`else
  assign stall = 1'b0;
`endif

  // Flush and stall produce the same bubble, so their overlap needs no extra priority.
  assign bubble = bus.MEM_ctrl_pc_src_i || stall;

  always_ff @(posedge clk_i) begin
    if (!n_rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (wb_en) begin
      rf[bus.WB_write_reg_i] <= bus.WB_write_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!n_rst_i) begin
      ex_pc      <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_ctrl    <= '0;
    end else begin
      ex_pc      <= bus.IFID_pc_i;
      ex_rs_data <= rs_data;
      ex_rt_data <= rt_data;
      ex_imm     <= imm;
      ex_rt      <= rt;
      ex_rd      <= rd;
      ex_ctrl    <= bubble ? ctrl_t'('0) : dec_ctrl;
    end
  end

  assign bus.stall_o                = stall;
  assign bus.IDEX_pc_o              = ex_pc;
  assign bus.IDEX_rs_data_o         = ex_rs_data;
  assign bus.IDEX_rt_data_o         = ex_rt_data;
  assign bus.IDEX_imm_o             = ex_imm;
  assign bus.IDEX_rt_o              = ex_rt;
  assign bus.IDEX_rd_o              = ex_rd;
  assign bus.IDEX_ctrl_reg_dst_o    = ex_ctrl.reg_dst;
  assign bus.IDEX_ctrl_alu_src_o    = ex_ctrl.alu_src;
  assign bus.IDEX_ctrl_branch_o     = ex_ctrl.branch;
  assign bus.IDEX_ctrl_mem_read_o   = ex_ctrl.mem_read;
  assign bus.IDEX_ctrl_mem_write_o  = ex_ctrl.mem_write;
  assign bus.IDEX_ctrl_reg_write_o  = ex_ctrl.reg_write;
  assign bus.IDEX_ctrl_mem_to_reg_o = ex_ctrl.mem_to_reg;
  assign bus.IDEX_ctrl_alu_op_o     = ex_ctrl.alu_op;
endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed vector table, hand sequences for load-use and flush,
// and random traffic against a cycle model built from the decode table and a register array.
module tb_id_stage;
`ifdef ID_HAZARD_DETECT_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif
  // ctrl = {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op[1:0]}
  localparam logic [8:0] C_R    = 9'b100100010;
  localparam logic [8:0] C_LW   = 9'b011110000;
  localparam logic [8:0] C_SW   = 9'b010001000;
  localparam logic [8:0] C_BEQ  = 9'b000000101;
  localparam logic [8:0] C_ADDI = 9'b010100000;

  typedef struct packed {
    logic [31:0] pc, rs_d, rt_d, imm;
    logic [4:0]  rt, rd;
    logic [8:0]  ctrl;
  } out_t;

  typedef struct {
    logic        rst_n;
    logic [31:0] pc, ir;
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        flush;
    logic [31:0] e_pc, e_rs, e_imm;
    logic [4:0]  e_rd;
    logic [8:0]  e_ctrl;
  } vec_t;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  id_stage_if bus();
  id_stage dut (.clk_i(clk), .n_rst_i(n_rst), .bus(bus));

  out_t got;
  assign got = {bus.IDEX_pc_o, bus.IDEX_rs_data_o, bus.IDEX_rt_data_o, bus.IDEX_imm_o,
                bus.IDEX_rt_o, bus.IDEX_rd_o, bus.IDEX_ctrl_reg_dst_o, bus.IDEX_ctrl_alu_src_o,
                bus.IDEX_ctrl_mem_to_reg_o, bus.IDEX_ctrl_reg_write_o, bus.IDEX_ctrl_mem_read_o,
                bus.IDEX_ctrl_mem_write_o, bus.IDEX_ctrl_branch_o, bus.IDEX_ctrl_alu_op_o};

  int checks = 0;
  int errors = 0;
  logic [31:0] m_rf [32];
  out_t        m_out;

  function automatic logic [8:0] decode(input logic [5:0] op);
    case (op)
      6'h00:   return C_R;
      6'h23:   return C_LW;
      6'h2B:   return C_SW;
      6'h04:   return C_BEQ;
      6'h08:   return C_ADDI;
      default: return 9'd0;
    endcase
  endfunction

  // What a read of register idx yields this cycle, including the pending WB value.
  function automatic logic [31:0] rd_reg(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (bus.WB_reg_write_i && bus.WB_write_reg_i == idx) return bus.WB_write_data_i;
    return m_rf[idx];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst_n, input logic [31:0] pc, input logic [31:0] ir,
                       input logic we, input logic [4:0] wreg, input logic [31:0] wdata,
                       input logic flush);
    n_rst                 = rst_n;
    bus.IFID_pc_i         = pc;
    bus.IFID_ir_i         = ir;
    bus.WB_reg_write_i    = we;
    bus.WB_write_reg_i    = wreg;
    bus.WB_write_data_i   = wdata;
    bus.MEM_ctrl_pc_src_i = flush;
  endtask

  // One clock: check stall against the model before the edge, then the IDEX outputs after it.
  task automatic step(input bit chk_stall, output logic st);
    out_t nxt;
    logic exp_stall;
    logic [4:0] rs, rt;
    #1;
    rs = bus.IFID_ir_i[25:21];
    rt = bus.IFID_ir_i[20:16];
    exp_stall = HAZ && m_out.ctrl[4] && (m_out.rt != 0) && (m_out.rt == rs || m_out.rt == rt);
    st = bus.stall_o;
    if (chk_stall) chk("stall_model", {63'd0, st}, {63'd0, exp_stall});
    nxt = '0;
    if (n_rst) begin
      nxt.pc   = bus.IFID_pc_i;
      nxt.rs_d = rd_reg(rs);
      nxt.rt_d = rd_reg(rt);
      nxt.imm  = {{16{bus.IFID_ir_i[15]}}, bus.IFID_ir_i[15:0]};
      nxt.rt   = rt;
      nxt.rd   = bus.IFID_ir_i[15:11];
      nxt.ctrl = (bus.MEM_ctrl_pc_src_i || exp_stall) ? 9'd0 : decode(bus.IFID_ir_i[31:26]);
    end
    @(posedge clk);
    #1;
    if (!n_rst) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    end else if (bus.WB_reg_write_i && bus.WB_write_reg_i != 0) begin
      m_rf[bus.WB_write_reg_i] = bus.WB_write_data_i;
    end
    m_out = nxt;
    checks++;
    if (got !== m_out) begin
      errors++;
      $display("FAIL idex_model got %h want %h", got, m_out);
    end
  endtask

  vec_t tbl [13];
  logic st;

  initial begin
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_out = '0;
    tbl[0]  = '{1'b0, 32'h04, 32'h8C220004, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 9'd0};
    tbl[1]  = '{1'b0, 32'h04, 32'h8C220004, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 9'd0};
    tbl[2]  = '{1'b1, 32'h08, 32'h00201020, 1'b0, 5'd0, 32'h0, 1'b0, 32'h08, 32'h0, 32'h1020, 5'd2, C_R};
    tbl[3]  = '{1'b1, 32'h0C, 32'hFC000000, 1'b1, 5'd5, 32'h12345678, 1'b0, 32'h0C, 32'h0, 32'h0, 5'd0, 9'd0};
    tbl[4]  = '{1'b1, 32'h10, 32'h00A63020, 1'b0, 5'd0, 32'h0, 1'b0, 32'h10, 32'h12345678, 32'h3020, 5'd6, C_R};
    tbl[5]  = '{1'b1, 32'h14, 32'h20E8FFFF, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 32'h14, 32'hDEADBEEF, 32'hFFFFFFFF, 5'd31, C_ADDI};
    tbl[6]  = '{1'b1, 32'h18, 32'h00000000, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 32'h18, 32'h0, 32'h0, 5'd0, C_R};
    tbl[7]  = '{1'b1, 32'h1C, 32'h00001820, 1'b0, 5'd0, 32'h0, 1'b0, 32'h1C, 32'h0, 32'h1820, 5'd3, C_R};
    tbl[8]  = '{1'b1, 32'h40, 32'h10220004, 1'b0, 5'd0, 32'h0, 1'b1, 32'h40, 32'h0, 32'h4, 5'd0, 9'd0};
    tbl[9]  = '{1'b1, 32'h44, 32'h10220004, 1'b0, 5'd0, 32'h0, 1'b0, 32'h44, 32'h0, 32'h4, 5'd0, C_BEQ};
    tbl[10] = '{1'b1, 32'h48, 32'hAC220008, 1'b0, 5'd0, 32'h0, 1'b0, 32'h48, 32'h0, 32'h8, 5'd0, C_SW};
    tbl[11] = '{1'b1, 32'h4C, 32'h8CA30000, 1'b0, 5'd0, 32'h0, 1'b0, 32'h4C, 32'h12345678, 32'h0, 5'd0, C_LW};
    tbl[12] = '{1'b1, 32'h50, 32'hFC000000, 1'b0, 5'd0, 32'h0, 1'b0, 32'h50, 32'h0, 32'h0, 5'd0, 9'd0};

    @(posedge clk);
    #1;
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].rst_n, tbl[i].pc, tbl[i].ir, tbl[i].we, tbl[i].wreg, tbl[i].wdata, tbl[i].flush);
      step(i > 0, st);
      if (i > 0) chk($sformatf("vec%0d_stall", i), {63'd0, st}, 64'd0);
      chk($sformatf("vec%0d_pc", i),   {32'd0, got.pc},   {32'd0, tbl[i].e_pc});
      chk($sformatf("vec%0d_rs", i),   {32'd0, got.rs_d}, {32'd0, tbl[i].e_rs});
      chk($sformatf("vec%0d_imm", i),  {32'd0, got.imm},  {32'd0, tbl[i].e_imm});
      chk($sformatf("vec%0d_rd", i),   {59'd0, got.rd},   {59'd0, tbl[i].e_rd});
      chk($sformatf("vec%0d_ctrl", i), {55'd0, got.ctrl}, {55'd0, tbl[i].e_ctrl});
    end

    // Load-use: lw r2,0(r1) then add r3,r2,r4 held in IFID while stalled.
    drive(1'b1, 32'h60, 32'h8C220000, 1'b0, 5'd0, 32'h0, 1'b0);
    step(1'b1, st);
    chk("lu_lw_ctrl", {55'd0, got.ctrl}, {55'd0, C_LW});
    drive(1'b1, 32'h64, 32'h00441820, 1'b0, 5'd0, 32'h0, 1'b0);
    step(1'b1, st);
    chk("lu_stall_hi", {63'd0, st}, {63'd0, HAZ});
    chk("lu_bubble_ctrl", {55'd0, got.ctrl}, {55'd0, (HAZ ? 9'd0 : C_R)});
    step(1'b1, st);
    chk("lu_stall_lo", {63'd0, st}, 64'd0);
    chk("lu_add_ctrl", {55'd0, got.ctrl}, {55'd0, C_R});

    // Stall and flush together: bubble, data still captured.
    drive(1'b1, 32'h70, 32'h8C220000, 1'b0, 5'd0, 32'h0, 1'b0);
    step(1'b1, st);
    drive(1'b1, 32'h74, 32'h00441820, 1'b0, 5'd0, 32'h0, 1'b1);
    step(1'b1, st);
    chk("fs_ctrl", {55'd0, got.ctrl}, 64'd0);
    chk("fs_pc", {32'd0, got.pc}, 64'h74);
    chk("fs_rd", {59'd0, got.rd}, 64'd3);

    // Random traffic against the model; small register range to provoke hazards and bypasses.
    for (int n = 0; n < 400; n++) begin
      logic [5:0]  op;
      logic [31:0] ir;
      case ($urandom_range(0, 5))
        0: op = 6'h00;
        1: op = 6'h23;
        2: op = 6'h2B;
        3: op = 6'h04;
        4: op = 6'h08;
        default: op = 6'($urandom);
      endcase
      ir = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
      drive(($urandom_range(0, 49) != 0), $urandom, ir, 1'($urandom),
            5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 7) == 0));
      step(1'b1, st);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
